pc_fetch_gen: RTL and testbench
===============================

// Module: pc_fetch_gen
// PURPOSE
//  Parametrised program-counter generator for the fetch stage. Holds the PC, issues fetch requests
//  to the I-cache over a valid/ready handshake, advances by a fixed stride, and tracks in-flight
//  fetch PCs in a FIFO so each cache response is tagged with its PC. Trap/branch redirects reload
//  the PC and flush in-flight fetches; stale responses are counted and dropped.
// PARAMETERS
//  XLEN       32  PC width in bits
//  RESET_VEC  0   PC value loaded on reset (XLEN bits)
//  STRIDE     4   PC increment per accepted request
//  QDEPTH     4   max outstanding fetches incl. ones awaiting discard; power of 2, >=2
// PORTS
//  clk               in   1     clock, rising edge
//  rst               in   1     asynchronous reset, active-high
//  stall_i           in   1     pipeline stall; blocks new requests
//  pc_write_i        in   1     PC write enable (hazard unit); low blocks new requests
//  trap_valid_i      in   1     trap/exception redirect request
//  trap_pc_i         in   XLEN  trap target
//  redirect_valid_i  in   1     branch/jump redirect request
//  redirect_pc_i     in   XLEN  branch target
//  req_valid_o       out  1     fetch request valid
//  req_pc_o          out  XLEN  fetch address (= pc_o)
//  req_ready_i       in   1     I-cache accepts request
//  rsp_valid_i       in   1     I-cache response, in request order
//  rsp_valid_o       out  1     response accepted for the current PC stream
//  rsp_pc_o          out  XLEN  PC belonging to that response
//  pc_o              out  XLEN  current PC register
//  inflight_o        out  $clog2(QDEPTH)+1  live FIFO occupancy
//  err_o             out  1     sticky protocol error
// BEHAVIOUR
//  - Reset (async, rst=1): pc_o=RESET_VEC, FIFO empty, inflight_o=0, discard count=0, err_o=0;
//    req_valid_o=0 and rsp_valid_o=0 while rst is high.
//  - redir = trap_valid_i | redirect_valid_i; target = trap_valid_i ? trap_pc_i : redirect_pc_i
//    (trap has priority).
//  - req_valid_o = pc_write_i & ~stall_i & ~redir & (inflight+discard < QDEPTH); combinational.
//  - Accept (req_valid_o & req_ready_i): push pc_o to FIFO; pc_o <= pc_o+STRIDE mod 2^XLEN,
//    next cycle. Otherwise pc_o holds unless redir.
//  - Redirect cycle: pc_o <= target next cycle; FIFO cleared;
//    discard <= discard + inflight - (rsp_valid_i ? 1 : 0). No request is issued that cycle.
//  - Response, non-redirect cycle: if discard>0 -> discard-1, rsp_valid_o=0. Else if inflight>0
//    -> rsp_valid_o=1, rsp_pc_o=FIFO head (same cycle, combinational), pop. Else err_o <= 1
//    (sticky until reset).
//  - Response during redirect cycle: rsp_valid_o=0; counted against the old stream as above.
//  - Push and pop same cycle: occupancy unchanged, ordering preserved.
//  - Full (inflight+discard == QDEPTH): req_valid_o=0 until a response frees a slot.
//  - Counter widths $clog2(QDEPTH)+1; pointers wrap mod QDEPTH.
//  - Assert rst mid-stream: everything returns to reset values immediately; pending responses
//    are not tracked.
// TESTING
//  1 Reset RESET_VEC=0x100: release rst, ready=1 3 cycles -> req_pc 0x100,0x104,0x108; pc_o=0x10C.
//  2 Stall: stall_i=1 with ready=1 -> req_valid_o=0, pc_o holds; deassert -> resumes same PC.
//  3 Full: ready=1, no responses, QDEPTH=4 -> exactly 4 accepts, then req_valid_o=0, inflight_o=4;
//    one rsp -> rsp_pc_o=first PC, 1 new request.
//  4 Redirect to 0x200 with 2 in flight -> next 2 rsp_valid_i dropped (rsp_valid_o=0), the next
//    req_pc_o=0x200, the following response tagged 0x200.
//  5 Trap 0x80 and redirect 0x300 in same cycle -> pc_o=0x80.
//  6 Wrap: pc_o=0xFFFF_FFFC accept -> pc_o=0x0; rsp_valid_i with FIFO empty -> err_o=1 and stays.

Source files
------------

// File: rtl/pc_fetch_gen.sv
// Program-counter generator for the fetch stage.
// Issues fetch requests over a valid/ready handshake, keeps the PCs of
// in-flight requests in a small FIFO so every cache response comes back
// tagged with its PC, and handles trap/branch redirects. After a redirect
// the responses still owed to the old stream are counted down and dropped.
module pc_fetch_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              STRIDE    = 4,
  parameter int              QDEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     pc_write_i,
  input  logic                     trap_valid_i,
  input  logic [XLEN-1:0]          trap_pc_i,
  input  logic                     redirect_valid_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic                     req_valid_o,
  output logic [XLEN-1:0]          req_pc_o,
  input  logic                     req_ready_i,
  input  logic                     rsp_valid_i,
  output logic                     rsp_valid_o,
  output logic [XLEN-1:0]          rsp_pc_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [$clog2(QDEPTH):0]  inflight_o,
  output logic                     err_o
);

  localparam int              PW       = $clog2(QDEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW:0]     QDEPTH_W = (CW+1)'(QDEPTH);
  localparam logic [XLEN-1:0] STRIDE_W = XLEN'(STRIDE);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fifo_mem [QDEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   discard_q;
  logic            err_q;

  logic            redir;
  logic [XLEN-1:0] target;
  logic [CW:0]     occupancy;
  logic            accept;
  logic            pop;

  // Redirect decode, request gating and response acceptance.
  // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    redir       = trap_valid_i | redirect_valid_i;
    target      = trap_valid_i ? trap_pc_i : redirect_pc_i;
    occupancy   = {1'b0, count_q} + {1'b0, discard_q};
    req_valid_o = !rst && pc_write_i && !stall_i && !redir && (occupancy < QDEPTH_W);
    accept      = req_valid_o && req_ready_i;
    pop         = !rst && rsp_valid_i && !redir && (discard_q == '0) && (count_q != '0);
  end

  // PC, FIFO pointers/occupancy, discard counter and sticky error.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_VEC;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      discard_q <= '0;
      err_q     <= 1'b0;
    end else if (redir) begin
      // Old stream is abandoned: everything still in flight becomes discard debt.
      pc_q     <= target;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      if (rsp_valid_i && count_q == '0 && discard_q == '0) begin
        err_q <= 1'b1;
      end else begin
        discard_q <= discard_q + count_q - CW'(rsp_valid_i);
      end
    end else begin
      if (accept) begin
        pc_q     <= pc_q + STRIDE_W;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(accept) - CW'(pop);
      if (rsp_valid_i) begin
        if (discard_q != '0) begin
          discard_q <= discard_q - 1'b1;
        end else if (count_q == '0) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // FIFO storage of issued PCs.
  // NOTE: storage has no reset; the pointers and occupancy alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr_q] <= pc_q;
    end
  end

  assign req_pc_o   = pc_q;
  assign pc_o       = pc_q;
  assign rsp_pc_o   = fifo_mem[rd_ptr_q];
  assign rsp_valid_o = pop;
  assign inflight_o = count_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Testbench for pc_fetch_gen: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the fetch stream.
module tb_pc_fetch_gen;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h100;
  localparam int          QD   = 4;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pc_write;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        rsp_valid_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_pc;
  logic [31:0] pc;
  logic [2:0]  inflight;
  logic        err;

  pc_fetch_gen #(
    .XLEN(XLEN), .RESET_VEC(RV), .STRIDE(4), .QDEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .pc_write_i(pc_write),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .req_valid_o(req_valid), .req_pc_o(req_pc), .req_ready_i(req_ready),
    .rsp_valid_i(rsp_valid_i), .rsp_valid_o(rsp_valid_o), .rsp_pc_o(rsp_pc),
    .pc_o(pc), .inflight_o(inflight), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: live in-flight PCs, responses owed to dead streams, PC, error.
  logic [31:0] mq[$];
  int          mdisc;
  logic [31:0] mpc;
  bit          merr;

  function automatic void model_reset();
    mq.delete();
    mdisc = 0;
    mpc   = RV;
    merr  = 1'b0;
  endfunction

  function automatic bit m_redir();
    return trap_valid || redirect_valid;
  endfunction

  function automatic bit m_req_valid();
    return !rst && pc_write && !stall && !m_redir() && (mq.size() + mdisc < QD);
  endfunction

  function automatic bit m_rsp_valid();
    return !rst && rsp_valid_i && !m_redir() && mdisc == 0 && mq.size() > 0;
  endfunction

  function automatic logic [31:0] m_rsp_pc();
    return (mq.size() > 0) ? mq[0] : 32'h0;
  endfunction

  // One clock: decide from pre-edge inputs, let the edge pass, advance the model.
  task automatic tick();
    bit          acc, rsp, rd, ts;
    logic [31:0] tgt;
    acc = m_req_valid() && req_ready;
    rsp = rsp_valid_i;
    rd  = m_redir();
    ts  = rst;
    tgt = trap_valid ? trap_pc : redirect_pc;
    @(posedge clk);
    if (ts) begin
      model_reset();
    end else if (rd) begin
      if (rsp && mq.size() + mdisc == 0) merr = 1'b1;
      else mdisc = mdisc + mq.size() - (rsp ? 1 : 0);
      mq.delete();
      mpc = tgt;
    end else begin
      if (rsp) begin
        if (mdisc > 0) mdisc--;
        else if (mq.size() > 0) void'(mq.pop_front());
        else merr = 1'b1;
      end
      if (acc) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; pc_write = 1; trap_valid = 0; redirect_valid = 0;
    trap_pc = 0; redirect_pc = 0; req_ready = 0; rsp_valid_i = 0;
  endtask

  // Return every outstanding response so the next scenario starts empty.
  task automatic drain();
    idle();
    for (int i = 0; i < 20 && (mq.size() + mdisc) > 0; i++) begin
      rsp_valid_i = 1;
      tick();
    end
    rsp_valid_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; rsp_valid_i = 1; req_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (pc !== RV) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, RV); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", req_valid); end
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_o); end
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL reset_inflight got=%0d want=0", inflight); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    rst = 0; rsp_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req_valid !== 1'b1 || req_pc !== RV + 32'(4*i))
        begin bad++; $display("FAIL boot_req[%0d] got=%b/%h want=1/%h", i, req_valid, req_pc, RV + 32'(4*i)); end
      tick();
    end
    req_ready = 0;
    #1;
    total++; if (pc !== 32'h10C) begin bad++; $display("FAIL boot_pc got=%h want=0000010c", pc); end
    total++; if (inflight !== 3'd3) begin bad++; $display("FAIL boot_inflight got=%0d want=3", inflight); end
    // Responses come back in order with their PCs.
    for (int i = 0; i < 3; i++) begin
      rsp_valid_i = 1;
      #1;
      total++; if (rsp_valid_o !== 1'b1 || rsp_pc !== RV + 32'(4*i))
        begin bad++; $display("FAIL boot_rsp[%0d] got=%b/%h want=1/%h", i, rsp_valid_o, rsp_pc, RV + 32'(4*i)); end
      tick();
    end
    idle();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    idle();
    #1;
    held = mpc;
    stall = 1; req_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid got=%b want=0", req_valid); end
      tick();
      total++; if (pc !== held) begin bad++; $display("FAIL stall_pc got=%h want=%h", pc, held); end
    end
    stall = 0; pc_write = 0;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL pcwrite_req_valid got=%b want=0", req_valid); end
    tick();
    pc_write = 1;
    #1;
    total++; if (req_valid !== 1'b1 || req_pc !== held)
      begin bad++; $display("FAIL stall_resume got=%b/%h want=1/%h", req_valid, req_pc, held); end
    tick();
    total++; if (pc !== held + 32'd4) begin bad++; $display("FAIL stall_advance got=%h want=%h", pc, held + 32'd4); end
    drain();
  endtask

  task automatic test_full();
    int          accepts;
    logic [31:0] first;
    idle();
    accepts = 0;
    first   = mpc;
    req_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req_valid) accepts++;
      tick();
    end
    #1;
    total++; if (accepts !== 4) begin bad++; $display("FAIL full_accepts got=%0d want=4", accepts); end
    total++; if (inflight !== 3'd4) begin bad++; $display("FAIL full_inflight got=%0d want=4", inflight); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid got=%b want=0", req_valid); end
    rsp_valid_i = 1;
    #1;
    total++; if (rsp_valid_o !== 1'b1 || rsp_pc !== first)
      begin bad++; $display("FAIL full_rsp got=%b/%h want=1/%h", rsp_valid_o, rsp_pc, first); end
    tick();
    rsp_valid_i = 0;
    #1;
    total++; if (req_valid !== 1'b1 || req_pc !== first + 32'd16)
      begin bad++; $display("FAIL full_refill got=%b/%h want=1/%h", req_valid, req_pc, first + 32'd16); end
    tick();
    #1;
    total++; if (req_valid !== 1'b0 || inflight !== 3'd4)
      begin bad++; $display("FAIL full_again got=%b/%0d want=0/4", req_valid, inflight); end
    drain();
  endtask

  task automatic test_redirect();
    idle();
    req_ready = 1;
    repeat (2) tick();
    redirect_valid = 1; redirect_pc = 32'h200;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL redir_req_valid got=%b want=0", req_valid); end
    tick();
    idle();
    #1;
    total++; if (pc !== 32'h200 || inflight !== 3'd0)
      begin bad++; $display("FAIL redir_pc got=%h/%0d want=00000200/0", pc, inflight); end
    for (int i = 0; i < 2; i++) begin
      rsp_valid_i = 1;
      #1;
      total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL redir_drop[%0d] got=%b want=0", i, rsp_valid_o); end
      tick();
    end
    rsp_valid_i = 0; req_ready = 1;
    #1;
    total++; if (req_valid !== 1'b1 || req_pc !== 32'h200)
      begin bad++; $display("FAIL redir_req got=%b/%h want=1/00000200", req_valid, req_pc); end
    tick();
    req_ready = 0; rsp_valid_i = 1;
    #1;
    total++; if (rsp_valid_o !== 1'b1 || rsp_pc !== 32'h200)
      begin bad++; $display("FAIL redir_rsp got=%b/%h want=1/00000200", rsp_valid_o, rsp_pc); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL redir_err got=%b want=0", err); end
    drain();
  endtask

  task automatic test_trap_priority();
    idle();
    trap_valid = 1; trap_pc = 32'h80; redirect_valid = 1; redirect_pc = 32'h300;
    tick();
    idle();
    #1;
    total++; if (pc !== 32'h80) begin bad++; $display("FAIL trap_prio got=%h want=00000080", pc); end
  endtask

  task automatic test_wrap_err();
    idle();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    idle(); req_ready = 1;
    #1;
    total++; if (req_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%h want=fffffffc", req_pc); end
    tick();
    req_ready = 0;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=00000000", pc); end
    rsp_valid_i = 1;
    tick();
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_early got=%b want=0", err); end
    tick();
    rsp_valid_i = 0;
    repeat (3) tick();
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
    rst = 1;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
    tick();
    rst = 0;
  endtask

  task automatic test_random();
    logic [31:0] exp_rpc;
    idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      stall          = ($urandom % 6) == 0;
      pc_write       = ($urandom % 7) != 0;
      req_ready      = ($urandom % 2) == 0;
      trap_valid     = ($urandom % 25) == 0;
      redirect_valid = ($urandom % 15) == 0;
      trap_pc        = $urandom & 32'hFFFF_FFFC;
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      rsp_valid_i    = (mq.size() + mdisc > 0) ? (($urandom % 3) != 0) : (($urandom % 60) == 0);
      #1;
      exp_rpc = m_rsp_pc();
      total++; if (req_valid !== m_req_valid())
        begin bad++; $display("FAIL rnd_req_valid cyc=%0d got=%b want=%b", cyc, req_valid, m_req_valid()); end
      total++; if (pc !== mpc || req_pc !== mpc)
        begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h/%h want=%h", cyc, pc, req_pc, mpc); end
      total++; if (rsp_valid_o !== m_rsp_valid())
        begin bad++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid_o, m_rsp_valid()); end
      if (m_rsp_valid()) begin
        total++; if (rsp_pc !== exp_rpc)
          begin bad++; $display("FAIL rnd_rsp_pc cyc=%0d got=%h want=%h", cyc, rsp_pc, exp_rpc); end
      end
      total++; if (inflight !== 3'(mq.size()) || err !== merr)
        begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d/%b want=%0d/%b", cyc, inflight, err, mq.size(), merr); end
      if (cyc == 250) begin
        // Asynchronous reset in the middle of the stream, away from any edge.
        #2;
        rst = 1;
        #1;
        total++; if (pc !== RV || inflight !== 3'd0 || req_valid !== 1'b0 || rsp_valid_o !== 1'b0)
          begin bad++; $display("FAIL async_rst got=%h/%0d/%b/%b want=%h/0/0/0", pc, inflight, req_valid, rsp_valid_o, RV); end
        model_reset();
        @(negedge clk);
        rst = 0;
      end else begin
        tick();
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_stall();
    test_full();
    test_redirect();
    test_trap_priority();
    test_wrap_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "time limit reached");
  end

endmodule
